// File: rtl/program_loader_if.sv
// Byte-stream input, RAM write port and CPU control bundle for the boot loader.
// slave is the loader's side of the bundle; master is the host/RAM/CPU side.
interface program_loader_if;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        haltTriggered;
    logic [31:0] ramAddr;
    logic [31:0] ramWData;
    logic        ramWE;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;

    modport slave (
        input  inByte, inValid, haltTriggered,
        output inReady, ramAddr, ramWData, ramWE, cpuReset, loadDone, loadError
    );

    modport master (
        output inByte, inValid, haltTriggered,
        input  inReady, ramAddr, ramWData, ramWE, cpuReset, loadDone, loadError
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a 16-bit word count and little-endian 32-bit words,
// writes them to CPU RAM and keeps the CPU in reset until the image is complete.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, RUN, ERR} state_t;

    localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

    state_t      stateReg;
    logic [7:0]  countLowReg;
    logic [15:0] wordTotalReg;
    logic [15:0] wordCntReg;
    logic [1:0]  byteIdxReg;
    logic [31:0] ramAddrReg;
    logic [31:0] ramWDataReg;
    logic        ramWEReg;

    logic        inReady;
    logic        transfer;
    logic [15:0] headerCount;
    logic        lastWord;
    logic [31:0] assembledWord;

    assign inReady     = (stateReg == HDR0) || (stateReg == HDR1) || (stateReg == DATA);
    assign transfer    = bus.inValid && inReady;
    assign headerCount = {bus.inByte, countLowReg};
    assign lastWord    = (wordCntReg + 16'd1) == wordTotalReg;

    // Lanes 0..2 hold the bytes received so far; lane 3 is taken straight
    // from the input when the word completes.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gLane
            logic [7:0] laneReg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    laneReg <= 8'd0;
                end else if (stateReg == DATA && transfer && byteIdxReg == 2'(gi)) begin
                    laneReg <= bus.inByte;
                end
            end
        end
    endgenerate

    assign assembledWord = {bus.inByte, gLane[2].laneReg, gLane[1].laneReg, gLane[0].laneReg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg     <= HDR0;
            countLowReg  <= 8'd0;
            wordTotalReg <= 16'd0;
            wordCntReg   <= 16'd0;
            byteIdxReg   <= 2'd0;
            ramAddrReg   <= BASE_ADDR;
            ramWDataReg  <= 32'd0;
            ramWEReg     <= 1'b0;
        end else begin
            ramWEReg <= 1'b0;
            case (stateReg)
                HDR0: begin
                    if (transfer) begin
                        countLowReg <= bus.inByte;
                        stateReg    <= HDR1;
                    end
                end
                HDR1: begin
                    if (transfer) begin
                        if ({1'b0, headerCount} > MAX_COUNT) begin
                            stateReg <= ERR;
                        end else if (headerCount == 16'd0) begin
                            stateReg <= RUN;
                        end else begin
                            wordTotalReg <= headerCount;
                            wordCntReg   <= 16'd0;
                            byteIdxReg   <= 2'd0;
                            stateReg     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (transfer) begin
                        byteIdxReg <= byteIdxReg + 2'd1;
                        if (byteIdxReg == 2'd3) begin
                            // Output registers are separate from the lanes, so
                            // the next word can start filling while this one is written.
                            ramWEReg    <= 1'b1;
                            ramWDataReg <= assembledWord;
                            ramAddrReg  <= BASE_ADDR + 32'(wordCntReg);
                            wordCntReg  <= wordCntReg + 16'd1;
                            if (lastWord) begin
                                stateReg <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    if (bus.haltTriggered) begin
                        wordCntReg <= 16'd0;
                        byteIdxReg <= 2'd0;
                        stateReg   <= HDR0;
                    end
                end
                ERR: begin
                    stateReg <= ERR;
                end
                default: begin
                    stateReg <= HDR0;
                end
            endcase
        end
    end

    assign bus.inReady   = inReady;
    assign bus.ramAddr   = ramAddrReg;
    assign bus.ramWData  = ramWDataReg;
    assign bus.ramWE     = ramWEReg;
    assign bus.cpuReset  = (stateReg != RUN);
    assign bus.loadDone  = (stateReg == RUN);
    assign bus.loadError = (stateReg == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a negedge monitor checks every RAM write
// against a queue of expected (address, data) pairs filled as images are sent.
module tb_program_loader;

    logic clk;
    logic reset;

    program_loader_if bus ();

    program_loader #(
        .BASE_ADDR (32'd0),
        .MAX_WORDS (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // RAM write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (bus.ramWE === 1'b1) begin
            $display("write addr=%h data=%h", bus.ramAddr, bus.ramWData);
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       bus.ramAddr, bus.ramWData);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                compared++;
                assert ({bus.ramAddr, bus.ramWData} === exp) else begin
                    mismatched++;
                    $error("FAIL write_data: observed %h_%h expected %h_%h",
                           bus.ramAddr, bus.ramWData, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one byte; the transfer happens on the next rising edge and
    // the task returns 1 time unit after it.
    task automatic sendByte(input logic [7:0] b);
        bus.inByte  = b;
        bus.inValid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        bus.inValid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic haltPulse();
        bus.inValid       = 1'b0;
        bus.haltTriggered = 1'b1;
        @(posedge clk);
        #1;
        bus.haltTriggered = 1'b0;
    endtask

    initial begin
        logic [7:0] imgA [10];
        imgA = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        reset             = 1'b0;
        bus.inByte        = 8'h00;
        bus.inValid       = 1'b0;
        bus.haltTriggered = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_inReady",   32'(bus.inReady),   32'd1);
        check("rst_cpuReset",  32'(bus.cpuReset),  32'd1);
        check("rst_loadDone",  32'(bus.loadDone),  32'd0);
        check("rst_loadError", 32'(bus.loadError), 32'd0);
        check("rst_ramWE",     32'(bus.ramWE),     32'd0);
        check("rst_ramAddr",   bus.ramAddr,        32'd0);
        check("rst_ramWData",  bus.ramWData,       32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Image A, back-to-back bytes.
        sb.push_back({32'd0, 32'h12345678});
        sb.push_back({32'd1, 32'hDEADBEEF});
        for (int i = 0; i < 6; i++) sendByte(imgA[i]);
        check("a_word0_we",       32'(bus.ramWE),    32'd1);
        check("a_word0_cpuReset", 32'(bus.cpuReset), 32'd1);
        for (int i = 6; i < 10; i++) sendByte(imgA[i]);
        check("a_word1_we",       32'(bus.ramWE),    32'd1);
        check("a_run_cpuReset",   32'(bus.cpuReset), 32'd0);
        check("a_run_loadDone",   32'(bus.loadDone), 32'd1);
        idleCycle();
        check("a_run_inReady",    32'(bus.inReady),  32'd0);
        check("a_run_we_low",     32'(bus.ramWE),    32'd0);
        check("a_all_written",    32'(sb.size()),    32'd0);

        haltPulse();
        check("halt_cpuReset", 32'(bus.cpuReset), 32'd1);
        check("halt_loadDone", 32'(bus.loadDone), 32'd0);
        check("halt_inReady",  32'(bus.inReady),  32'd1);

        // Image A again with inValid toggling every cycle.
        sb.push_back({32'd0, 32'h12345678});
        sb.push_back({32'd1, 32'hDEADBEEF});
        for (int i = 0; i < 10; i++) begin
            sendByte(imgA[i]);
            if (i < 9) idleCycle();
        end
        check("b_run_loadDone", 32'(bus.loadDone), 32'd1);
        repeat (3) idleCycle();
        check("b_all_written",  32'(sb.size()),    32'd0);

        // Empty image: RUN right after the second header byte.
        haltPulse();
        sendByte(8'h00);
        check("z_hdr1_cpuReset", 32'(bus.cpuReset), 32'd1);
        sendByte(8'h00);
        check("z_run_loadDone",  32'(bus.loadDone), 32'd1);
        check("z_run_cpuReset",  32'(bus.cpuReset), 32'd0);
        check("z_no_write",      32'(bus.ramWE),    32'd0);

        // Single-word image after halt.
        haltPulse();
        sb.push_back({32'd0, 32'hDDCCBBAA});
        sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD);
        check("c_run_loadDone", 32'(bus.loadDone), 32'd1);
        idleCycle();
        check("c_all_written",  32'(sb.size()),    32'd0);

        // Asynchronous reset out of RUN, observed before the next edge.
        #2;
        reset = 1'b0;
        #1;
        check("arst_run_cpuReset", 32'(bus.cpuReset), 32'd1);
        check("arst_run_loadDone", 32'(bus.loadDone), 32'd0);
        check("arst_run_inReady",  32'(bus.inReady),  32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Oversized header 1025 -> ERR; later bytes and halt are ignored.
        sendByte(8'h01);
        sendByte(8'h04);
        check("err_loadError", 32'(bus.loadError), 32'd1);
        check("err_inReady",   32'(bus.inReady),   32'd0);
        check("err_cpuReset",  32'(bus.cpuReset),  32'd1);
        for (int i = 0; i < 6; i++) sendByte(8'(8'h10 + i));
        haltPulse();
        check("err_stuck",     32'(bus.loadError), 32'd1);
        check("err_stuck_rdy", 32'(bus.inReady),   32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("err_rst_loadError", 32'(bus.loadError), 32'd0);
        check("err_rst_inReady",   32'(bus.inReady),   32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-word: partial bytes must be discarded.
        sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h11); sendByte(8'h22);
        bus.inValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_cpuReset", 32'(bus.cpuReset), 32'd1);
        check("mid_ramWE",    32'(bus.ramWE),    32'd0);
        check("mid_ramAddr",  bus.ramAddr,       32'd0);
        check("mid_inReady",  32'(bus.inReady),  32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.push_back({32'd0, 32'h11223344});
        sendByte(8'h01); sendByte(8'h00);
        sendByte(8'h44); sendByte(8'h33); sendByte(8'h22); sendByte(8'h11);
        check("mid_reload_done", 32'(bus.loadDone), 32'd1);
        repeat (2) idleCycle();
        check("final_sb_empty",  32'(sb.size()),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader directly upstream of the single-cycle CPU and its RAM.
- Accepts a byte stream (host link / UART receiver) framed as a 16-bit little-endian word count followed by that many 32-bit little-endian words.
- Writes those words into the CPU RAM write port and holds the CPU in reset until the image is complete.
- Re-arms for a new image when the CPU signals halt.

Parameters:
- BASE_ADDR, 0, word address of the first loaded word.
- MAX_WORDS, 1024, largest accepted word count; a larger header is an error.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clk).
- inByte  input  8  incoming stream byte.
- inValid  input  1  inByte valid.
- inReady  output  1  loader accepts inByte this cycle; a transfer is inValid && inReady.
- haltTriggered  input  1  CPU halt indication; re-arms the loader.
- ramAddr  output  32  RAM word address of the write.
- ramWData  output  32  RAM write data.
- ramWE  output  1  RAM write strobe, one cycle per word.
- cpuReset  output  1  active-high hold-reset for the CPU.
- loadDone  output  1  image loaded, CPU running.
- loadError  output  1  header exceeded MAX_WORDS.

Behaviour:
- States: HDR0, HDR1, DATA, RUN, ERR. All outputs are registered or derived from the state register only.
- Reset values: state=HDR0; inReady=1; ramWE=0; ramAddr=BASE_ADDR; ramWData=0; cpuReset=1; loadDone=0; loadError=0; byte index=0; word counter=0.
- inReady=1 in HDR0/HDR1/DATA; inReady=0 in RUN/ERR. Stalls on inValid=0 are unlimited, and no state changes occur without a transfer.
- HDR0: on transfer, latch the count low byte, then go to HDR1.
- HDR1: on transfer, form count = {inByte, low}.
  - count > MAX_WORDS: go to ERR.
  - count = 0: go to RUN (no RAM writes).
  - otherwise: go to DATA, with word counter=0 and byte index=0.
- DATA: each transfer shifts into the assembly register at byte lane = byte index; byte 0 is LSB.
  - On the 4th byte (index 3), the next cycle shows ramWE=1, ramWData=assembled word, and ramAddr=BASE_ADDR+word counter.
  - The word counter then increments and the byte index wraps to 0.
  - The ramWData/ramAddr output registers are separate from the assembly register. A transfer in the same cycle ramWE is high is legal and does not corrupt the write, so sustained inValid=1 gives full throughput of 1 byte/cycle.
  - When the final word's 4th byte is accepted, the next state is RUN.
  - The ramWE pulse for the final word and the first RUN cycle coincide.
- RUN: cpuReset=0, loadDone=1, no RAM writes. If haltTriggered=1 in any RUN cycle, the next cycle is HDR0 with cpuReset=1, loadDone=0, and word counter/byte index cleared.
- haltTriggered is ignored outside RUN.
- ERR: cpuReset=1, loadError=1, inReady=0. This state is left only via reset.
- cpuReset is exactly (state != RUN).
- Reset mid-image: discard the partial word and counters, return to HDR0, assert cpuReset immediately (asynchronously). RAM contents already written are not touched.
- Word counter width: 16 bits. ramAddr arithmetic is 32-bit unsigned and wraps modulo 2^32.

Test Plan:
- Reset release, then bytes 02 00 | 78 56 34 12 | EF BE AD DE with inValid held high.
  - Required: ramWE at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF; cpuReset falls and loadDone rises in the cycle of the second ramWE.
- Same image with inValid toggling 1/0 every cycle.
  - Required: identical writes, and no extra or duplicated ramWE.
- Header 00 00.
  - Required: no ramWE, and RUN entered the cycle after the second header byte.
- Header 01 04 (1025 > MAX_WORDS).
  - Required: loadError=1, inReady=0, cpuReset stays 1, and further bytes are ignored; after reset, loadError=0.
- After a load, pulse haltTriggered in RUN.
  - Required: next cycle cpuReset=1, state HDR0; a second image 01 00 AA BB CC DD writes 0xDDCCBBAA at addr BASE_ADDR.
- Assert reset asynchronously after 2 data bytes.
  - Required: outputs at reset values before the next clk edge, and no ramWE for the partial word.
